// File: rtl/dma_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : dma_multi_channel
//  Purpose  : NUM_CH-channel burst DMA engine. Each channel accepts a command
//             (base address, length in words) from the cpu, then moves words
//             from its external device into data memory. The bus is stolen
//             from the cpu through the BR/BG handshake one burst at a time,
//             and released after every burst. Channels are served round-robin.
//             Each channel raises a one-cycle completion interrupt.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk        rising-edge clock
//    reset      asynchronous active-high reset
//    cmd_valid  cpu presents a command
//    cmd_ch     target channel of the command
//    cmd_addr   destination base address
//    cmd_len    transfer length in words (0 = immediate completion)
//    cmd_ready  target channel cmd_ch is idle (combinational)
//    BR         bus request to cpu
//    BG         bus grant from cpu
//    edata      device words, channel c word k at [(c*BURST_LEN+k)*WORD_SIZE]
//    dev_sel    channel currently owning the bus
//    offset     word index within the current burst
//    WRITE      memory write strobe
//    addr       memory address (meaningful while BG=1)
//    data       memory write data (meaningful while BG=1)
//    busy       per-channel active flag
//    interrupt  per-channel completion pulse
// ============================================================================
module dma_multi_channel #(
    parameter int WORD_SIZE = 16,
    parameter int BURST_LEN = 4,
    parameter int NUM_CH    = 2,
    parameter int CH_W      = 1,
    parameter int OFF_W     = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_valid,
    input  logic [CH_W-1:0]                   cmd_ch,
    input  logic [WORD_SIZE-1:0]              cmd_addr,
    input  logic [WORD_SIZE-1:0]              cmd_len,
    output logic                              cmd_ready,
    output logic                              BR,
    input  logic                              BG,
    input  logic [NUM_CH*BURST_LEN*WORD_SIZE-1:0] edata,
    output logic [CH_W-1:0]                   dev_sel,
    output logic [OFF_W-1:0]                  offset,
    output logic                              WRITE,
    output logic [WORD_SIZE-1:0]              addr,
    output logic [WORD_SIZE-1:0]              data,
    output logic [NUM_CH-1:0]                 busy,
    output logic [NUM_CH-1:0]                 interrupt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WORD_SIZE-1:0] r_base [NUM_CH];
    logic [WORD_SIZE-1:0] r_rem  [NUM_CH];
    logic [NUM_CH-1:0]    r_busy;
    logic [NUM_CH-1:0]    r_irq;
    logic [CH_W-1:0]      r_dev_sel;
    logic [CH_W-1:0]      r_ptr;
    logic [OFF_W-1:0]     r_offset;

    logic [CH_W-1:0]      w_rr_ch;
    logic [CH_W-1:0]      w_rr_idx;
    logic                 w_rr_found;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_last_word;
    logic                 w_burst_end;
    logic [WORD_SIZE-1:0] w_words [NUM_CH][BURST_LEN];

    // Unpack the flat device bus into a [channel][word] view.
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            for (genvar k = 0; k < BURST_LEN; k++) begin : g_word
                assign w_words[c][k] = edata[(c*BURST_LEN+k)*WORD_SIZE +: WORD_SIZE];
            end
        end
    endgenerate

    assign cmd_ready   = (int'(cmd_ch) < NUM_CH) && !r_busy[cmd_ch];
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_step      = (r_state == S_XFER) && BG;
    assign w_last_word = (r_rem[r_dev_sel] == WORD_SIZE'(1));
    assign w_burst_end = w_step && (w_last_word || (r_offset == OFF_W'(BURST_LEN-1)));

    // Round-robin pick: scan from the farthest candidate back to the one just
    // after the pointer, so the nearest busy channel is the last (winning) hit.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_ch    = '0;
        w_rr_idx   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_rr_idx = CH_W'((int'(r_ptr) + i) % NUM_CH);
            if (r_busy[w_rr_idx]) begin
                w_rr_found = 1'b1;
                w_rr_ch    = w_rr_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        BR          = 1'b0;
        WRITE       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rr_found) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                BR = 1'b1;
                if (BG) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                BR    = 1'b1;
                WRITE = BG;
                if (w_burst_end) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                // Hold here until the cpu has actually taken the bus back.
                if (!BG) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Channel bookkeeping. A command can only target an idle channel while
    // the bus owner is always busy, so accept and step never hit the same
    // channel in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= '0;
            r_irq     <= '0;
            r_dev_sel <= '0;
            r_offset  <= '0;
            r_ptr     <= CH_W'(NUM_CH-1);
            for (int c = 0; c < NUM_CH; c++) begin
                r_base[c] <= '0;
                r_rem[c]  <= '0;
            end
        end else begin
            r_irq <= '0;
            if ((r_state == S_IDLE) && w_rr_found) begin
                r_dev_sel <= w_rr_ch;
            end
            if (w_accept) begin
                r_base[cmd_ch] <= cmd_addr;
                r_rem[cmd_ch]  <= cmd_len;
                if (cmd_len == '0) begin
                    r_irq[cmd_ch] <= 1'b1;
                end else begin
                    r_busy[cmd_ch] <= 1'b1;
                end
            end
            if (w_step) begin
                r_base[r_dev_sel] <= r_base[r_dev_sel] + WORD_SIZE'(1);
                r_rem[r_dev_sel]  <= r_rem[r_dev_sel] - WORD_SIZE'(1);
                r_offset          <= r_offset + OFF_W'(1);
                if (w_burst_end) begin
                    // Completion is flagged on entry to RELEASE so the
                    // interrupt is a single pulse however long RELEASE lasts.
                    r_offset <= '0;
                    r_ptr    <= r_dev_sel;
                    if (w_last_word) begin
                        r_busy[r_dev_sel] <= 1'b0;
                        r_irq[r_dev_sel]  <= 1'b1;
                    end
                end
            end
        end
    end

    assign dev_sel   = r_dev_sel;
    assign offset    = r_offset;
    assign busy      = r_busy;
    assign interrupt = r_irq;
    assign addr      = (r_state == S_XFER) ? r_base[r_dev_sel] : '0;
    assign data      = (r_state == S_XFER) ? w_words[r_dev_sel][r_offset] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dma_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_multi_channel
//  Purpose  : Self-checking bench for dma_multi_channel. A cpu model echoes
//             BR onto BG one cycle later (optionally stalling it), every
//             memory write is recorded, and the recorded stream is compared
//             with a word-level round-robin model of the transfers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_multi_channel;

    localparam int WS = 16;
    localparam int BL = 4;
    localparam int NC = 2;
    localparam int CW = 1;
    localparam int OW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid;
    logic [CW-1:0]       cmd_ch;
    logic [WS-1:0]       cmd_addr;
    logic [WS-1:0]       cmd_len;
    logic                cmd_ready;
    logic                BR;
    logic                BG;
    logic [NC*BL*WS-1:0] edata;
    logic [CW-1:0]       dev_sel;
    logic [OW-1:0]       offset;
    logic                WRITE;
    logic [WS-1:0]       addr;
    logic [WS-1:0]       data;
    logic [NC-1:0]       busy;
    logic [NC-1:0]       interrupt;

    dma_multi_channel #(
        .WORD_SIZE(WS), .BURST_LEN(BL), .NUM_CH(NC), .CH_W(CW), .OFF_W(OW)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .BR(BR), .BG(BG), .edata(edata), .dev_sel(dev_sel), .offset(offset),
        .WRITE(WRITE), .addr(addr), .data(data), .busy(busy),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [OW-1:0] off;
        logic [WS-1:0] a;
        logic [WS-1:0] d;
    } wr_t;

    int checks   = 0;
    int failures = 0;

    // observation
    wr_t wr_q[$];
    int  wr_cyc[$];
    int  irq_ch_q[$];
    int  irq_cyc_q[$];
    int  cyc, acc_cyc, br_rises, min_gap, gap_cnt;
    logic br_s, br_d, bg_forced, rand_stall;
    int  hold_cnt;

    // model
    int            m_len  [NC];
    logic [WS-1:0] m_addr [NC];
    wr_t           exp_q[$];
    int            exp_irq[$];

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [WS-1:0] word(input int ch, input int k);
        return edata[(ch*BL+k)*WS +: WS];
    endfunction

    // Word-level reference: the first-issued channel goes first, then each
    // burst goes to the next channel (after the last served) with words left.
    task automatic model_run(input int first);
        int rem[NC];
        int pos[NC];
        int ch, n, total;
        bit found;
        wr_t w;
        exp_q.delete();
        exp_irq.delete();
        total = 0;
        for (int c = 0; c < NC; c++) begin
            rem[c] = m_len[c];
            pos[c] = 0;
            total += m_len[c];
        end
        ch = first;
        while (total > 0) begin
            n = (rem[ch] < BL) ? rem[ch] : BL;
            for (int k = 0; k < n; k++) begin
                w.ch  = CW'(ch);
                w.off = OW'(k);
                w.a   = m_addr[ch] + WS'(pos[ch]);
                w.d   = word(ch, k);
                exp_q.push_back(w);
                pos[ch]++;
            end
            rem[ch] -= n;
            total   -= n;
            if (rem[ch] == 0) exp_irq.push_back(ch);
            found = 1'b0;
            for (int i = 1; i <= NC; i++) begin
                if (!found && rem[(ch+i)%NC] > 0) begin
                    found = 1'b1;
                    ch    = (ch+i) % NC;
                end
            end
        end
    endtask

    task automatic clear_obs();
        wr_q.delete(); wr_cyc.delete(); irq_ch_q.delete(); irq_cyc_q.delete();
        br_rises = 0; min_gap = 1000; gap_cnt = 0; br_s = BR;
    endtask

    // One clock: the cpu model updates BG 1 ns after the edge, outputs are
    // sampled 2 ns after the edge.
    task automatic cycle();
        wr_t w;
        @(posedge clk);
        cyc++;
        #1;
        bg_forced = 1'b0;
        if (hold_cnt > 0) begin
            BG = 1'b0; hold_cnt--; bg_forced = 1'b1;
        end else if (rand_stall && $urandom_range(3) == 0) begin
            BG = 1'b0; bg_forced = 1'b1;
        end else begin
            BG = br_d;
        end
        br_d = BR;
        #1;
        if (BG && WRITE) begin
            w.ch = dev_sel; w.off = offset; w.a = addr; w.d = data;
            wr_q.push_back(w);
            wr_cyc.push_back(cyc);
        end
        for (int c = 0; c < NC; c++) begin
            if (interrupt[c]) begin
                irq_ch_q.push_back(c);
                irq_cyc_q.push_back(cyc);
            end
        end
        if (BR && !br_s) begin
            br_rises++;
            if (br_rises > 1 && gap_cnt < min_gap) min_gap = gap_cnt;
        end
        gap_cnt = BR ? 0 : gap_cnt + 1;
        br_s = BR;
    endtask

    task automatic apply_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_addr = '0; cmd_len = '0;
        BG = 1'b0; br_d = 1'b0; hold_cnt = 0; rand_stall = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        for (int c = 0; c < NC; c++) begin
            m_len[c] = 0; m_addr[c] = '0;
        end
        clear_obs();
    endtask

    task automatic rand_edata();
        for (int i = 0; i < NC*BL; i++) edata[i*WS +: WS] = WS'($urandom);
    endtask

    task automatic issue(input int ch, input logic [WS-1:0] a, input logic [WS-1:0] len,
                         output logic rdy);
        cmd_valid = 1'b1; cmd_ch = CW'(ch); cmd_addr = a; cmd_len = len;
        #1;
        rdy = cmd_ready;
        cycle();
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int q = 0;
        for (int n = 0; n < budget && q < 3; n++) begin
            cycle();
            if (busy == '0 && !BR && !BG) q++; else q = 0;
        end
        if (q < 3) begin
            checks++; failures++;
            $display("FAIL quiet_timeout busy=%b BR=%b after %0d cycles", busy, BR, budget);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({BR, WRITE, busy, interrupt} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got BR=%b WRITE=%b busy=%b irq=%b required all 0", BR, WRITE, busy, interrupt);
        end
        checks++;
        if ({offset, dev_sel, addr, data} !== '0) begin
            failures++;
            $display("FAIL reset_dp got off=%0d sel=%0d addr=%h data=%h required 0", offset, dev_sel, addr, data);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        logic rdy;
        int bad, t0;
        apply_reset();
        rand_edata();
        m_len[0] = 12; m_addr[0] = 16'h01F4;
        issue(0, 16'h01F4, 16'd12, rdy);
        t0 = acc_cyc;
        wait_quiet(400);
        model_run(0);
        checks++;
        if (rdy !== 1'b1) begin failures++; $display("FAIL single_ready got %b required 1", rdy); end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL single_count got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            bad = -1;
            foreach (exp_q[i]) if (bad < 0 && wr_q[i] !== exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                failures++; $display("FAIL single_write[%0d] got %h required %h", bad, wr_q[bad], exp_q[bad]);
            end
            checks++;
            if (wr_cyc[0] - t0 != 3) begin
                failures++; $display("FAIL single_latency got %0d required 3", wr_cyc[0] - t0);
            end
            checks++;
            if (irq_ch_q.size() != 1 || irq_ch_q[0] != 0 || irq_cyc_q[0] != wr_cyc[wr_cyc.size()-1] + 1) begin
                failures++; $display("FAIL single_irq got %0d pulses required 1 on ch0 right after last write", irq_ch_q.size());
            end
        end
        checks++;
        if (br_rises != 3 || min_gap < 1) begin
            failures++; $display("FAIL single_bursts got rises=%0d gap=%0d required 3 and >=1", br_rises, min_gap);
        end
    endtask

    task automatic test_two();
        logic r0, r1;
        int bad;
        apply_reset();
        rand_edata();
        m_len[0] = 8; m_addr[0] = 16'h0100;
        m_len[1] = 8; m_addr[1] = 16'h0200;
        issue(0, 16'h0100, 16'd8, r0);
        issue(1, 16'h0200, 16'd8, r1);
        wait_quiet(600);
        model_run(0);
        checks++;
        if (!(r0 && r1)) begin failures++; $display("FAIL two_ready got %b%b required 11", r0, r1); end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL two_count got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            bad = -1;
            foreach (exp_q[i]) if (bad < 0 && wr_q[i] !== exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                failures++; $display("FAIL two_write[%0d] got %h required %h", bad, wr_q[bad], exp_q[bad]);
            end
        end
        checks++;
        if (irq_ch_q != exp_irq) begin
            failures++; $display("FAIL two_irq_order got %p required %p", irq_ch_q, exp_irq);
        end
        checks++;
        if (br_rises != 4) begin failures++; $display("FAIL two_bursts got %0d required 4", br_rises); end
    endtask

    task automatic test_tail();
        logic rdy;
        logic [WS-1:0] base;
        int bad;
        apply_reset();
        rand_edata();
        base = WS'($urandom);
        m_len[1] = 6; m_addr[1] = base;
        issue(1, base, 16'd6, rdy);
        wait_quiet(400);
        model_run(1);
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL tail_count got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            bad = -1;
            foreach (exp_q[i]) if (bad < 0 && wr_q[i] !== exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                failures++; $display("FAIL tail_write[%0d] got %h required %h", bad, wr_q[bad], exp_q[bad]);
            end
            checks++;
            if (wr_q[5].a !== base + 16'd5 || wr_q[5].off !== OW'(1)) begin
                failures++; $display("FAIL tail_last got addr=%h off=%0d required %h off=1", wr_q[5].a, wr_q[5].off, base + 16'd5);
            end
        end
        checks++;
        if (br_rises != 2) begin failures++; $display("FAIL tail_bursts got %0d required 2", br_rises); end
    endtask

    task automatic test_grant_withdrawal();
        logic rdy;
        logic [WS-1:0] base;
        bit trig;
        int bad, nforced;
        apply_reset();
        rand_edata();
        base = WS'($urandom);
        m_len[0] = 8; m_addr[0] = base;
        issue(0, base, 16'd8, rdy);
        trig = 1'b0; nforced = 0;
        for (int n = 0; n < 300 && busy != '0; n++) begin
            cycle();
            if (bg_forced) begin
                nforced++;
                checks++;
                if (WRITE !== 1'b0 || addr !== base + 16'd2) begin
                    failures++; $display("FAIL grant_gap got WRITE=%b addr=%h required 0 and %h", WRITE, addr, base + 16'd2);
                end
            end
            if (!trig && wr_q.size() == 2) begin
                trig = 1'b1; hold_cnt = 3;
            end
        end
        wait_quiet(100);
        model_run(0);
        checks++;
        if (nforced != 3) begin failures++; $display("FAIL grant_stall got %0d cycles required 3", nforced); end
        checks++;
        if (wr_q.size() != 8) begin
            failures++; $display("FAIL grant_count got %0d required 8", wr_q.size());
        end else begin
            bad = -1;
            foreach (exp_q[i]) if (bad < 0 && wr_q[i] !== exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                failures++; $display("FAIL grant_write[%0d] got %h required %h", bad, wr_q[bad], exp_q[bad]);
            end
        end
    endtask

    task automatic test_edge();
        logic rdy, rdy1, rdy0, rdyx;
        logic [WS-1:0] base1;
        logic [63:0] ch0_addrs;
        int bad;
        apply_reset();
        rand_edata();
        // zero length: pulse in the cycle following the accepting edge
        issue(0, WS'($urandom), 16'd0, rdy);
        repeat (5) cycle();
        checks++;
        if (irq_ch_q.size() != 1 || irq_ch_q[0] != 0 || irq_cyc_q[0] != acc_cyc) begin
            failures++; $display("FAIL zero_irq got %0d pulses required 1 on ch0 next cycle", irq_ch_q.size());
        end
        checks++;
        if (br_rises != 0 || busy !== '0) begin
            failures++; $display("FAIL zero_bus got rises=%0d busy=%b required 0", br_rises, busy);
        end
        clear_obs();
        base1 = WS'($urandom);
        m_len[1] = 8; m_addr[1] = base1;
        m_len[0] = 4; m_addr[0] = 16'hFFFE;
        issue(1, base1, 16'd8, rdy1);
        issue(0, 16'hFFFE, 16'd4, rdy0);
        issue(1, 16'h1234, 16'd3, rdyx);
        checks++;
        if (rdyx !== 1'b0) begin failures++; $display("FAIL busy_ready got %b required 0", rdyx); end
        wait_quiet(600);
        model_run(1);
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL edge_count got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            bad = -1;
            foreach (exp_q[i]) if (bad < 0 && wr_q[i] !== exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                failures++; $display("FAIL edge_write[%0d] got %h required %h", bad, wr_q[bad], exp_q[bad]);
            end
        end
        ch0_addrs = '0;
        foreach (wr_q[i]) if (wr_q[i].ch == 1'b0) ch0_addrs = {ch0_addrs[47:0], wr_q[i].a};
        checks++;
        if (ch0_addrs !== 64'hFFFE_FFFF_0000_0001) begin
            failures++; $display("FAIL wrap_addrs got %h required fffeffff00000001", ch0_addrs);
        end
        checks++;
        if (irq_ch_q.size() != 2) begin failures++; $display("FAIL edge_irqs got %0d required 2", irq_ch_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic rdy;
        logic [WS-1:0] base;
        int bad;
        apply_reset();
        rand_edata();
        issue(0, WS'($urandom), 16'd8, rdy);
        for (int n = 0; n < 20 && wr_q.size() == 0; n++) cycle();
        checks++;
        if (wr_q.size() == 0) begin failures++; $display("FAIL rmid_start got 0 writes required >=1"); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({BR, WRITE, busy, interrupt} !== '0) begin
            failures++; $display("FAIL rmid_async got BR=%b WRITE=%b busy=%b irq=%b required 0", BR, WRITE, busy, interrupt);
        end
        #2;
        reset = 1'b0;
        m_len[0] = 0;
        clear_obs();
        repeat (10) cycle();
        checks++;
        if (wr_q.size() != 0 || irq_ch_q.size() != 0 || br_rises != 0) begin
            failures++; $display("FAIL rmid_quiet got w=%0d irq=%0d br=%0d required 0", wr_q.size(), irq_ch_q.size(), br_rises);
        end
        base = WS'($urandom);
        m_len[1] = 5; m_addr[1] = base;
        issue(1, base, 16'd5, rdy);
        wait_quiet(400);
        model_run(1);
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rmid_count got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            bad = -1;
            foreach (exp_q[i]) if (bad < 0 && wr_q[i] !== exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                failures++; $display("FAIL rmid_write[%0d] got %h required %h", bad, wr_q[bad], exp_q[bad]);
            end
        end
        checks++;
        if (irq_ch_q.size() != 1 || irq_ch_q[0] != 1) begin
            failures++; $display("FAIL rmid_irq got %0d pulses required 1 on ch1", irq_ch_q.size());
        end
    endtask

    task automatic test_random();
        logic r0, r1;
        int first, other, bad;
        for (int it = 0; it < 6; it++) begin
            apply_reset();
            rand_edata();
            rand_stall = 1'b1;
            first = int'($urandom_range(1));
            other = 1 - first;
            m_len[first]  = int'($urandom_range(1, 13)); m_addr[first] = WS'($urandom);
            m_len[other]  = int'($urandom_range(1, 13)); m_addr[other] = WS'($urandom);
            issue(first, m_addr[first], WS'(m_len[first]), r0);
            issue(other, m_addr[other], WS'(m_len[other]), r1);
            wait_quiet(2000);
            rand_stall = 1'b0;
            model_run(first);
            checks++;
            if (wr_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_count got %0d required %0d", it, wr_q.size(), exp_q.size());
            end else begin
                bad = -1;
                foreach (exp_q[i]) if (bad < 0 && wr_q[i] !== exp_q[i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    failures++; $display("FAIL rand%0d_write[%0d] got %h required %h", it, bad, wr_q[bad], exp_q[bad]);
                end
            end
            checks++;
            if (irq_ch_q != exp_irq) begin
                failures++; $display("FAIL rand%0d_irq got %p required %p", it, irq_ch_q, exp_irq);
            end
        end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_single();
        test_two();
        test_tail();
        test_grant_withdrawal();
        test_edge();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
